// File: rtl/nbit_mux_pipe.sv
// nbit_mux_pipe: M-to-1, N-bit selector feeding a STAGES-deep register chain.
// Each stage carries {data, valid, err}. Stall holds every stage and flush
// loads every stage with the bubble value. A synchronous reset does the same.
// The outputs come straight from the last stage, so no input reaches an
// output through combinational logic alone.
module nbit_mux_pipe #(
    parameter int unsigned N         = 32,
    parameter int unsigned M         = 4,
    parameter int unsigned STAGES    = 1,
    parameter logic [31:0] FLUSH_VAL = 32'h0000_0013,
    parameter int unsigned SELW      = $clog2(M)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [M*N-1:0]    in_bus,
    input  logic [SELW-1:0]   sel,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [N-1:0]      out_data,
    output logic              out_valid,
    output logic              sel_err
);

    // Bubble payload. It is truncated or extended to the data width.
    localparam logic [N-1:0] BUBBLE_DATA = N'(FLUSH_VAL);

    logic [N-1:0] mux_data;
    logic         mux_err;

    logic [N-1:0] data_q  [STAGES];
    logic [N-1:0] data_d  [STAGES];
    logic         valid_q [STAGES];
    logic         valid_d [STAGES];
    logic         err_q   [STAGES];
    logic         err_d   [STAGES];

    // Input select. An index with no matching slice falls back to input 0
    // and raises err.
    always_comb begin
        mux_data = in_bus[N-1:0];
        mux_err  = 1'b1;
        for (int unsigned k = 0; k < M; k++) begin
            if (sel == SELW'(k)) begin
                mux_data = in_bus[k*N +: N];
                mux_err  = 1'b0;
            end
        end
    end

    // Next-state logic. Flush takes priority over stall. Otherwise the chain
    // either holds or shifts by one stage.
    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            data_d[i]  = data_q[i];
            valid_d[i] = valid_q[i];
            err_d[i]   = err_q[i];
        end
        if (flush) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_d[i]  = BUBBLE_DATA;
                valid_d[i] = 1'b0;
                err_d[i]   = 1'b0;
            end
        end else if (!stall) begin
            data_d[0]  = mux_data;
            valid_d[0] = in_valid;
            err_d[0]   = mux_err;
            for (int unsigned i = 1; i < STAGES; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
                err_d[i]   = err_q[i-1];
            end
        end
    end

    // Stage registers with synchronous reset to the bubble value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i]  <= BUBBLE_DATA;
                valid_q[i] <= 1'b0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i]  <= data_d[i];
                valid_q[i] <= valid_d[i];
                err_q[i]   <= err_d[i];
            end
        end
    end

    assign out_data  = data_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];
    assign sel_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_nbit_mux_pipe.sv
// tb_nbit_mux_pipe: four instances share one stimulus stream.
// Instances 0/1/2 use M=4 with STAGES=1/2/3. Instance 3 uses M=3 with STAGES=1.
// Issued entries are queued per instance. A negedge monitor pops and checks
// each entry when it appears at the output, including its arrival edge.
module tb_nbit_mux_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic [127:0] bus = '0;
    logic [1:0]   sel = '0;

    logic [31:0]  od [4];
    logic         ov [4];
    logic         oe [4];

    typedef struct {
        logic [31:0] d;
        logic        e;
        int unsigned cyc;
        int unsigned stl;
    } exp_t;

    exp_t        sb [4][$];
    int unsigned stg [4] = '{1, 2, 3, 1};
    int unsigned mm  [4] = '{4, 4, 4, 3};

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    int unsigned stall_edges = 0;
    logic        last_rst = 1'b1;
    logic        last_flush = 1'b0;
    logic        last_stall = 1'b0;
    logic [31:0] snap_d [4];
    logic        snap_v [4];

    always #5 clk = ~clk;

    nbit_mux_pipe #(.N(32), .M(4), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_bus(bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush),
        .out_data(od[0]), .out_valid(ov[0]), .sel_err(oe[0]));

    nbit_mux_pipe #(.N(32), .M(4), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst), .in_bus(bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush),
        .out_data(od[1]), .out_valid(ov[1]), .sel_err(oe[1]));

    nbit_mux_pipe #(.N(32), .M(4), .STAGES(3)) u_s3 (
        .clk(clk), .rst(rst), .in_bus(bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush),
        .out_data(od[2]), .out_valid(ov[2]), .sel_err(oe[2]));

    nbit_mux_pipe #(.N(32), .M(3), .STAGES(1)) u_m3 (
        .clk(clk), .rst(rst), .in_bus(bus[95:0]), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush),
        .out_data(od[3]), .out_valid(ov[3]), .sel_err(oe[3]));

    // Edge bookkeeping: the edge count, the control values seen at the last
    // edge, and the number of effective stall edges.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        last_rst   <= rst;
        last_flush <= flush;
        last_stall <= stall;
        if (!rst && !flush && stall) stall_edges <= stall_edges + 1;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic mon(input int idx);
        exp_t x;
        if (last_rst === 1'b0 && last_flush === 1'b0 && last_stall === 1'b0 && ov[idx] === 1'b1) begin
            if (sb[idx].size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid dut%0d: got data %h expected no valid output", idx, od[idx]);
            end else begin
                x = sb[idx].pop_front();
                chk("data", idx, od[idx], x.d);
                chk("sel_err", idx, {31'b0, oe[idx]}, {31'b0, x.e});
                chk("latency_edge", idx, cyc, x.cyc + stg[idx] + (stall_edges - x.stl));
            end
        end
    endtask

    // Monitor: check every newly presented valid entry against the queue.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) mon(i);
    end

    function automatic logic [127:0] mk(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic step(input logic [127:0] b, input logic [1:0] s, input logic v,
                        input logic st, input logic fl, input logic r);
        exp_t        x;
        int unsigned pick;
        bus = b; sel = s; in_valid = v; stall = st; flush = fl; rst = r;
        if (!r && !fl && !st && v) begin
            for (int i = 0; i < 4; i++) begin
                pick  = (s < mm[i]) ? int'(s) : 0;
                x.d   = b[pick*32 +: 32];
                x.e   = (s >= mm[i]);
                x.cyc = cyc;
                x.stl = stall_edges;
                sb[i].push_back(x);
            end
        end
        @(posedge clk);
        #1;
        if (r || fl) begin
            for (int i = 0; i < 4; i++) sb[i].delete();
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_idle(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_data"}, i, od[i], 32'h0000_0013);
            chk({tag, "_valid"}, i, {31'b0, ov[i]}, 32'd0);
            chk({tag, "_err"}, i, {31'b0, oe[i]}, 32'd0);
        end
    endtask

    initial begin
        logic [127:0] b4;

        // Reset held for two edges with random inputs.
        for (int k = 0; k < 2; k++) begin
            step({$urandom, $urandom, $urandom, $urandom}, 2'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'b1);
            chk_idle("reset");
        end
        idle(1);

        // Basic select over all four indices.
        b4 = mk(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
        for (int k = 0; k < 4; k++) step(b4, 2'(k), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Latency stream.
        step(mk(32'hA, 32'h0, 32'h0, 32'h0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(mk(32'hB, 32'h0, 32'h0, 32'h0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(mk(32'hC, 32'h0, 32'h0, 32'h0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Stall for three edges after the second issue. The inputs offered
        // during the stall must be ignored.
        step(mk(32'h1, 32'h0, 32'h0, 32'h0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(mk(32'h0, 32'h2, 32'h0, 32'h0), 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            snap_d[i] = od[i];
            snap_v[i] = ov[i];
        end
        for (int k = 0; k < 3; k++) begin
            step(mk(32'hBAD, 32'hBAD, 32'hBAD, 32'hBAD), 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                chk("stall_hold_data", i, od[i], snap_d[i]);
                chk("stall_hold_valid", i, {31'b0, ov[i]}, {31'b0, snap_v[i]});
            end
        end
        step(mk(32'h3, 32'h0, 32'h0, 32'h0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(mk(32'h0, 32'h0, 32'h4, 32'h0), 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Flush and stall on the same edge with valid data in flight.
        step(mk(32'h55, 32'h0, 32'h0, 32'h0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(mk(32'h66, 32'h0, 32'h0, 32'h0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(mk(32'h77, 32'h0, 32'h0, 32'h0), 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_idle("flush");
        step(mk(32'h88, 32'h0, 32'h0, 32'h0), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Out-of-range select for M=3, then an in-range entry.
        b4 = mk(32'h0000_DEAD, 32'h0000_BEEF, 32'h0000_CAFE, 32'h0000_F00D);
        step(b4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(b4, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // An err entry is followed by a reset mid-stream.
        step(b4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_err", 3, {31'b0, oe[3]}, 32'd1);
        step(b4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_idle("midreset");
        idle(4);

        for (int i = 0; i < 4; i++) chk("queue_drained", i, sb[i].size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nbit_mux_pipe.md
Name: nbit_mux_pipe

Overview:
- Parametrised M-to-1, N-bit selector followed by a configurable-depth pipeline register chain, with stall (hold) and flush (bubble) control.
- Successor to the fixed 4-input combinational selector.
- Used at pipeline-stage boundaries, e.g. forwarding/operand selection feeding the EX stage. It merges select and stage register so stall/flush semantics are consistent at one point.

Parameters:
- N, 32, data width in bits (>=1).
- M, 4, number of data inputs (2..16).
- STAGES, 1, register stages between select and output (1..4); latency in cycles.
- FLUSH_VAL, 32'h00000013, value loaded on flush/reset (RV32I NOP); only low N bits used.
- SELW, $clog2(M), derived select width; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_bus  in  M*N  flattened inputs; input k occupies bits [k*N+N-1 : k*N].
- sel  in  SELW  input index.
- in_valid  in  1  qualifies the current selection.
- stall  in  1  hold all stages.
- flush  in  1  invalidate all stages.
- out_data  out  N  data from last stage (registered).
- out_valid  out  1  valid from last stage.
- sel_err  out  1  last-stage flag: the entry was captured with sel >= M.

Behaviour:
- Select, combinational:
  - sel < M: pick in_bus slice sel.
  - sel >= M (possible only when M is not a power of 2): pick input 0 and set err = 1.
- Pipeline: STAGES entries, each holding {data[N], valid, err}.
  - Stage 0 captures the select result, in_valid and err.
  - Stage i captures stage i-1.
  - Outputs drive from stage STAGES-1.
- Latency: a value presented at edge t appears on out_data after edge t+STAGES-1. Example: STAGES=1 gives visibility after the same edge.
- Priority each edge: rst > flush > stall > advance.
  - rst=1: every stage data = FLUSH_VAL[N-1:0], valid = 0, err = 0. Outputs therefore read FLUSH_VAL/0/0 from the first edge with rst high. Reset mid-stream discards all in-flight entries.
  - flush=1 (rst=0): every stage takes the reset values, regardless of stall. The input presented on that edge is discarded.
  - stall=1 (rst=0, flush=0): all stages hold; inputs ignored. No entry is lost or duplicated across a stall of any length.
  - Otherwise: shift by one stage.
- Data is captured even when in_valid=0 (bubble carries data). Consumers qualify with out_valid only.
- err is registered with its data and travels through the pipeline. It is never sticky across entries.
- No combinational path from any input to any output.
- Deassertion of rst: the first capture happens on the next edge with rst=0 and stall=0.

Test Plan:
- Reset, M=4, N=32, STAGES=1: hold rst for 2 edges with random inputs -> out_data=0x00000013, out_valid=0, sel_err=0.
- Basic select, STAGES=1: inputs 0x11111111/0x22222222/0x33333333/0x44444444; sel 0,1,2,3 on successive edges with in_valid=1 -> out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 after each respective edge, out_valid=1.
- Latency, STAGES=3: issue 0xA, 0xB, 0xC on consecutive edges -> 0xA visible after the 3rd edge, then 0xB, then 0xC; out_valid low before that.
- Stall, STAGES=2: stream 1,2,3,4 with stall high for 3 edges after the 2nd issue -> out_data holds throughout the stall. Output order is 1,2,3,4 with no repeats or drops.
- Flush with stall, STAGES=2: flush=1 and stall=1 on the same edge with valid data in flight -> out_valid=0, out_data=0x00000013 after that edge. The next issued value appears 2 edges later.
- Out-of-range select, M=3: sel=3, input0=0xDEAD -> out_data=0xDEAD, sel_err=1. The following sel=1 entry has sel_err=0. A rst mid-stream clears sel_err.
